demux1_2_reg: RTL

- Registered 1-to-2 demultiplexer: the counterpart of the 2-to-1 channel mux. It steers one W-bit input word to output channel 0 or 1, selected by Controle.
- Each output channel has a one-word holding register with a valid/ready handshake. A slow consumer on one channel stalls only that channel.
- Sits between the datapath result bus and two destinations, e.g. register-file write port and memory/output port, in the 8-bit processor.

---
 rtl/demux1_2_reg.sv | 91 +++++++++
 1 files changed

// File: rtl/demux1_2_reg.sv
// ============================================================================
// Module   : demux1_2_reg
// Purpose  : Registered 1-to-2 demultiplexer with a one-word valid/ready
//            holding register per output channel. The optional per-channel
//            drain counters are enabled by defining DEMUX_CONTADOR_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux1_2_reg #(
    parameter int W = 4
) (
    input  logic         Clock,
    input  logic         Resetn,
    input  logic [W-1:0] Entrada,
    input  logic         Controle,
    input  logic         EntradaValida,
    output logic         EntradaPronta,
    output logic [W-1:0] Saida0,
    output logic         Valida0,
    input  logic         Pronta0,
    output logic [W-1:0] Saida1,
    output logic         Valida1,
    input  logic         Pronta1
`ifdef DEMUX_CONTADOR_EN
    ,
    output logic [7:0]   Contagem0,
    output logic [7:0]   Contagem1
`endif
);

    logic [W-1:0] data_q  [2];
    logic [1:0]   valid_q;
    logic [1:0]   ready;
    logic [1:0]   accept;
    logic [1:0]   drain;
    logic         take;

    assign ready = {Pronta1, Pronta0};

    // Only the selected channel decides whether the input word can be taken.
    assign EntradaPronta = Controle ? (~valid_q[1] | Pronta1)
                                    : (~valid_q[0] | Pronta0);
    assign take          = EntradaValida & EntradaPronta;
    assign accept        = {take & Controle, take & ~Controle};
    assign drain         = valid_q & ready;

    generate
        for (genvar ch = 0; ch < 2; ch++) begin : g_ch
            // Accept wins over drain so a full channel can stream 1 word/cycle.
            always_ff @(posedge Clock or negedge Resetn) begin
                if (!Resetn) begin
                    valid_q[ch] <= 1'b0;
                    data_q[ch]  <= '0;
                end else if (accept[ch]) begin
                    valid_q[ch] <= 1'b1;
                    data_q[ch]  <= Entrada;
                end else if (drain[ch]) begin
                    valid_q[ch] <= 1'b0;
                end
            end
        end
    endgenerate

    assign Saida0  = data_q[0];
    assign Saida1  = data_q[1];
    assign Valida0 = valid_q[0];
    assign Valida1 = valid_q[1];

`ifdef DEMUX_CONTADOR_EN
    logic [7:0] count_q [2];

    generate
        for (genvar ch = 0; ch < 2; ch++) begin : g_cnt
            always_ff @(posedge Clock or negedge Resetn) begin
                if (!Resetn) begin
                    count_q[ch] <= 8'd0;
                end else if (drain[ch]) begin
                    count_q[ch] <= count_q[ch] + 8'd1;
                end
            end
        end
    endgenerate

    assign Contagem0 = count_q[0];
    assign Contagem1 = count_q[1];
`endif

endmodule

`default_nettype wire
